// File: rtl/gcd_pkg.sv
// Shared constants for the GCD share arbiter: FSM encodings, default
// parameter values and the helper that picks one requester's operand slice.
package gcd_pkg;

    localparam int GCD_WIDTH_DEF   = 4;
    localparam int GCD_TIMEOUT_DEF = 64;
    localparam int GCD_CNT_W_DEF   = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Returns requester idx's operand in the low bits of the result.
    // Callers pack two width-bit fields into bus and truncate the result.
    function automatic logic [31:0] op_slice(input logic [63:0] bus,
                                             input logic        idx,
                                             input int unsigned width);
        logic [63:0] sh;
        sh = idx ? (bus >> width) : bus;
        return sh[31:0];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to
// the requester that was not served last.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_win,
    output logic       o_any
);

    // Tie-break against the previous winner; otherwise follow the single request.
    always_comb begin
        o_any = |i_req;
        if (i_req == 2'b11) o_win = ~i_last;
        else                o_win = i_req[1];
    end

endmodule

// File: rtl/gcd_share_arbiter.sv
// Shares one subtract-loop GCD engine between two requesters. Operands of the
// round-robin winner are latched, the engine is started and watched by a
// timeout counter, and the result is returned to the winner. Zero operands
// bypass the engine because its subtract loop never ends on zero.
module gcd_share_arbiter
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH_DEF,
    parameter int TIMEOUT = GCD_TIMEOUT_DEF,
    parameter int CNT_W   = GCD_CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [2*WIDTH-1:0] x_in,
    input  logic [2*WIDTH-1:0] y_in,
    output logic [1:0]         grant,
    output logic [1:0]         res_valid,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_err,
    output logic               busy,
    output logic               gcd_start,
    output logic [WIDTH-1:0]   gcd_x,
    output logic [WIDTH-1:0]   gcd_y,
    output logic               gcd_abort,
    input  logic               gcd_done,
    input  logic [WIDTH-1:0]   gcd_result
);

    logic [1:0]       r_state;
    logic [1:0]       r_grant;
    logic [1:0]       r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic             r_res_err;
    logic             r_busy;
    logic             r_gcd_start;
    logic [WIDTH-1:0] r_gcd_x;
    logic [WIDTH-1:0] r_gcd_y;
    logic             r_gcd_abort;
    logic [CNT_W-1:0] r_wdog;
    logic             r_last;
    logic             r_id;

    logic             w_win;
    logic             w_any;
    logic [WIDTH-1:0] w_x_win;
    logic [WIDTH-1:0] w_y_win;
    logic             w_zero;
    logic             w_wd_exp;
    logic [1:0]       w_id_1h;
    logic [1:0]       w_nxt;

    rr_arb2 u_arb (
        .i_req  (req),
        .i_last (r_last),
        .o_win  (w_win),
        .o_any  (w_any)
    );

    assign w_x_win  = WIDTH'(op_slice(64'(x_in), w_win, WIDTH));
    assign w_y_win  = WIDTH'(op_slice(64'(y_in), w_win, WIDTH));
    assign w_zero   = (r_gcd_x == '0) || (r_gcd_y == '0);
    assign w_wd_exp = (r_wdog == CNT_W'(TIMEOUT - 1));
    assign w_id_1h  = r_id ? 2'b10 : 2'b01;

    // Next state. ISSUE is the grant cycle: latched operands are inspected
    // there, so a zero operand jumps straight to RESP without starting the engine.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_nxt = ST_ISSUE;
            ST_ISSUE: w_nxt = w_zero ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (gcd_done || w_wd_exp) w_nxt = ST_RESP;
            default:  w_nxt = ST_IDLE;
        endcase
    end

    // State, pulses and datapath. Each output is set on the transition into
    // the cycle in which it must be seen, so all outputs stay registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_res_valid <= '0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_gcd_start <= 1'b0;
            r_gcd_x     <= '0;
            r_gcd_y     <= '0;
            r_gcd_abort <= 1'b0;
            r_wdog      <= '0;
            r_last      <= 1'b1;
            r_id        <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_busy      <= (w_nxt != ST_IDLE);
            r_grant     <= '0;
            r_res_valid <= '0;
            r_gcd_start <= 1'b0;
            r_gcd_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_win ? 2'b10 : 2'b01;
                        r_gcd_x <= w_x_win;
                        r_gcd_y <= w_y_win;
                        r_id    <= w_win;
                        r_last  <= w_win;
                    end
                end
                ST_ISSUE: begin
                    if (w_zero) begin
                        // gcd(a,0)=a and gcd(0,0)=0 both reduce to a bitwise OR
                        r_res_data  <= r_gcd_x | r_gcd_y;
                        r_res_err   <= 1'b0;
                        r_res_valid <= w_id_1h;
                    end else begin
                        r_gcd_start <= 1'b1;
                        r_wdog      <= '0;
                    end
                end
                ST_WAIT: begin
                    r_wdog <= r_wdog + CNT_W'(1);
                    if (gcd_done) begin
                        // done beats a coincident timeout
                        r_res_data  <= gcd_result;
                        r_res_err   <= 1'b0;
                        r_res_valid <= w_id_1h;
                    end else if (w_wd_exp) begin
                        r_gcd_abort <= 1'b1;
                        r_res_data  <= '0;
                        r_res_err   <= 1'b1;
                        r_res_valid <= w_id_1h;
                    end
                end
                default: ;
            endcase
        end
    end

    assign grant     = r_grant;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign busy      = r_busy;
    assign gcd_start = r_gcd_start;
    assign gcd_x     = r_gcd_x;
    assign gcd_y     = r_gcd_y;
    assign gcd_abort = r_gcd_abort;

endmodule

// File: tb/tb_gcd_share_arbiter.sv
// Directed bench for gcd_share_arbiter with a behavioural engine whose
// latency, result and hang behaviour are set per job.
module tb_gcd_share_arbiter;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 32;
    localparam int CNT_W   = 6;

    logic               clk   = 1'b0;
    logic               reset = 1'b1;
    logic [1:0]         req   = '0;
    logic [2*WIDTH-1:0] x_in  = '0;
    logic [2*WIDTH-1:0] y_in  = '0;
    logic [1:0]         grant;
    logic [1:0]         res_valid;
    logic [WIDTH-1:0]   res_data;
    logic               res_err;
    logic               busy;
    logic               gcd_start;
    logic [WIDTH-1:0]   gcd_x;
    logic [WIDTH-1:0]   gcd_y;
    logic               gcd_abort;
    logic               gcd_done   = 1'b0;
    logic [WIDTH-1:0]   gcd_result = '0;

    int n_chk = 0;
    int n_err = 0;

    int               eng_lat  = 4;
    bit               eng_hang = 1'b0;
    logic [WIDTH-1:0] eng_val  = '0;
    int               e_cnt    = 0;
    bit               e_act    = 1'b0;

    always #5 clk = ~clk;

    gcd_share_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .x_in       (x_in),
        .y_in       (y_in),
        .grant      (grant),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_err    (res_err),
        .busy       (busy),
        .gcd_start  (gcd_start),
        .gcd_x      (gcd_x),
        .gcd_y      (gcd_y),
        .gcd_abort  (gcd_abort),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result)
    );

    // Engine model: done pulses eng_lat+1 cycles after the start cycle.
    always @(posedge clk) begin
        if (reset) begin
            e_act    <= 1'b0;
            e_cnt    <= 0;
            gcd_done <= 1'b0;
        end else begin
            gcd_done <= 1'b0;
            if (gcd_start) begin
                if (!eng_hang) begin
                    e_act <= 1'b1;
                    e_cnt <= eng_lat;
                end
            end else if (e_act) begin
                if (e_cnt <= 1) begin
                    gcd_done   <= 1'b1;
                    gcd_result <= eng_val;
                    e_act      <= 1'b0;
                end
                e_cnt <= e_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One job from request to the idle cycle after res_valid.
    // lat = cycles from gcd_start to res_valid; 0 selects the zero-operand path.
    task automatic job(input string tag, input logic [1:0] rq, input logic [1:0] eg,
                       input logic [WIDTH-1:0] ex, input logic [WIDTH-1:0] ey,
                       input logic [WIDTH-1:0] ed, input logic ee,
                       input int lat, input bit hold);
        int k;
        int n_ab;
        req = rq;
        @(negedge clk);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        if (!hold) req = req & ~eg;
        @(negedge clk);
        if (lat == 0) begin
            chk({tag, ".nostart"}, 32'(gcd_start), 32'd0);
            chk({tag, ".rv"}, 32'(res_valid), 32'(eg));
            chk({tag, ".data"}, 32'(res_data), 32'(ed));
            chk({tag, ".err"}, 32'(res_err), 32'd0);
        end else begin
            chk({tag, ".start"}, 32'(gcd_start), 32'd1);
            chk({tag, ".gx"}, 32'(gcd_x), 32'(ex));
            chk({tag, ".gy"}, 32'(gcd_y), 32'(ey));
            k    = 0;
            n_ab = 0;
            while (res_valid == 2'b00 && k < 200) begin
                @(negedge clk);
                k++;
                if (gcd_abort) n_ab++;
            end
            chk({tag, ".lat"}, 32'(k), 32'(lat));
            chk({tag, ".rv"}, 32'(res_valid), 32'(eg));
            chk({tag, ".data"}, 32'(res_data), 32'(ed));
            chk({tag, ".err"}, 32'(res_err), 32'(ee));
            chk({tag, ".aborts"}, 32'(n_ab), 32'(ee));
            chk({tag, ".abort_now"}, 32'(gcd_abort), 32'(ee));
        end
        @(negedge clk);
        chk({tag, ".rv_pulse"}, 32'(res_valid), 32'd0);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".grant"}, 32'(grant), 32'd0);
        chk({tag, ".rv"}, 32'(res_valid), 32'd0);
        chk({tag, ".data"}, 32'(res_data), 32'd0);
        chk({tag, ".err"}, 32'(res_err), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".start"}, 32'(gcd_start), 32'd0);
        chk({tag, ".gx"}, 32'(gcd_x), 32'd0);
        chk({tag, ".gy"}, 32'(gcd_y), 32'd0);
        chk({tag, ".abort"}, 32'(gcd_abort), 32'd0);
    endtask

    initial begin
        int rv_seen;
        repeat (3) @(negedge clk);
        chk_idle_outs("rst");
        reset = 1'b0;

        // single requester, engine path: gcd(12,8)=4, done 5 cycles after start
        x_in[3:0] = 4'd12; y_in[3:0] = 4'd8;
        eng_lat = 4; eng_val = 4'd4;
        job("eng", 2'b01, 2'b01, 4'd12, 4'd8, 4'd4, 1'b0, 6, 1'b0);

        // contention straight out of reset: requester 0 first
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        x_in = {4'd15, 4'd9}; y_in = {4'd10, 4'd6};
        eng_val = 4'd3;
        job("c0", 2'b11, 2'b01, 4'd9, 4'd6, 4'd3, 1'b0, 6, 1'b0);
        eng_val = 4'd5;
        job("c1", 2'b10, 2'b10, 4'd15, 4'd10, 4'd5, 1'b0, 6, 1'b0);

        // both held: grants alternate
        eng_val = 4'd3;
        job("a0", 2'b11, 2'b01, 4'd9, 4'd6, 4'd3, 1'b0, 6, 1'b1);
        eng_val = 4'd5;
        job("a1", 2'b11, 2'b10, 4'd15, 4'd10, 4'd5, 1'b0, 6, 1'b1);
        eng_val = 4'd3;
        job("a2", 2'b11, 2'b01, 4'd9, 4'd6, 4'd3, 1'b0, 6, 1'b1);
        req = 2'b00;

        // zero short-circuit
        x_in[7:4] = 4'd0; y_in[7:4] = 4'd9;
        job("z0", 2'b10, 2'b10, 4'd0, 4'd9, 4'd9, 1'b0, 0, 1'b0);
        y_in[7:4] = 4'd0;
        job("z1", 2'b10, 2'b10, 4'd0, 4'd0, 4'd0, 1'b0, 0, 1'b0);

        // engine hangs: abort 32 cycles after start
        x_in[3:0] = 4'd5; y_in[3:0] = 4'd3;
        eng_hang = 1'b1;
        job("to", 2'b01, 2'b01, 4'd5, 4'd3, 4'd0, 1'b1, TIMEOUT, 1'b0);

        // done on the last watchdog cycle, also proves the watchdog restarted
        eng_hang = 1'b0; eng_lat = TIMEOUT - 2; eng_val = 4'd7;
        x_in[3:0] = 4'd14; y_in[3:0] = 4'd7;
        job("dt", 2'b01, 2'b01, 4'd14, 4'd7, 4'd7, 1'b0, TIMEOUT, 1'b0);

        // reset while waiting on a hung engine
        x_in[3:0] = 4'd12; y_in[3:0] = 4'd8;
        eng_hang = 1'b1;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle_outs("rw");
        rv_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid != 2'b00) rv_seen++;
        end
        chk("rw.no_rv", 32'(rv_seen), 32'd0);
        eng_hang = 1'b0; eng_lat = 4; eng_val = 4'd4;
        x_in[7:4] = 4'd3; y_in[7:4] = 4'd3;
        job("rw2", 2'b11, 2'b01, 4'd12, 4'd8, 4'd4, 1'b0, 6, 1'b0);
        req = 2'b00;

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
